sram_ctrl: RTL and testbench
============================

# sram_ctrl

Parametrised memory-stage bridge between the core's word-wide data memory port and the off-chip asynchronous SRAM (DQ/ADDR/WE_N pins). It splits each read or write into several SRAM-width beats, inserts programmable wait states per beat, and stalls the pipeline through `ready` until the access completes. It generalises the earlier fixed 16-bit, single-cycle arrangement to arbitrary core/SRAM width ratios and SRAM speeds.

## Interface
Parameters:
- `DATA_W`, default 32: core data width. Must equal `SRAM_DQ_W * BEATS`, with BEATS a power of two ≥ 1.
- `SRAM_DQ_W`, default 16: SRAM data pin width.
- `SRAM_ADDR_W`, default 18: SRAM address pin width.
- `WAIT_CYCLES`, default 1: extra cycles each beat is held. Range 0..15.
- `ADDR_OFFSET`, default 0: subtracted from `req_addr` before mapping.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `req_wr_en`, in, 1: write request, level, held until `ready`.
- `req_rd_en`, in, 1: read request, level, held until `ready`.
- `req_addr`, in, 32: byte address, word-aligned.
- `req_wdata`, in, DATA_W: write data.
- `rdata`, out, DATA_W: read data, valid while `ready` is high in DONE.
- `ready`, out, 1: low means stall the pipeline.
- `SRAM_DQ`, inout, SRAM_DQ_W: SRAM data. Driven only during write beats, else high-Z.
- `SRAM_ADDR`, out, SRAM_ADDR_W: SRAM half-word address.
- `SRAM_WE_N`, out, 1: SRAM write enable, active-low.

## Operation
- FSM states:
  - IDLE: if `req_wr_en | req_rd_en`, go to ACCESS. Clear the beat and wait counters. Latch op, address and wdata.
  - ACCESS: runs beats 0..BEATS-1. The wait counter runs 0..WAIT_CYCLES. When the wait counter reaches WAIT_CYCLES:
    - If beat < BEATS-1: beat++ and clear the wait counter.
    - Else: go to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Request priority: if both enables are high, the access is a write. The read is not performed.
- Address mapping:
  - word = (latched_addr − ADDR_OFFSET) >> log2(DATA_W/8), mod 2^32.
  - `SRAM_ADDR` = (word·BEATS + beat), truncated to SRAM_ADDR_W bits. Out-of-range addresses wrap silently.
- Beat order: beat k carries bits [(k+1)·SRAM_DQ_W−1 : k·SRAM_DQ_W]. The low half-word goes first.
- Write beats:
  - `SRAM_WE_N` = 0 for every cycle of the beat.
  - `SRAM_DQ` = latched wdata slice.
- Read beats:
  - `SRAM_WE_N` = 1 and `SRAM_DQ` = Z.
  - `SRAM_DQ` is sampled into the `rdata` slice on the clock edge that ends the beat (wait counter = WAIT_CYCLES).
- `rdata` holds its value until the next read overwrites it. Writes leave it unchanged.
- `ready` = (IDLE and no request) or DONE. It is combinational from state and enables.
- In IDLE, `SRAM_WE_N` = 1, `SRAM_DQ` = Z, and `SRAM_ADDR` holds its last value.

## Timing
- Reset values (rst low, asynchronous):
  - state IDLE; counters 0; `rdata` 0; `SRAM_ADDR` 0; `SRAM_WE_N` 1; `SRAM_DQ` Z.
  - `ready` is 1 when no request is present.
- Request latency: `ready` is low for 1 + BEATS·(WAIT_CYCLES+1) cycles and high for one cycle in DONE.
  - Defaults (BEATS 2, WAIT 1): 5 cycles low, ready in the 6th.
  - WAIT 0: 3 cycles low.
- The request-acceptance cycle (IDLE with request) drives no SRAM activity. The first beat starts on the next cycle.
- The pipeline advances on the DONE edge. Enables seen in DONE are not re-sampled. A back-to-back request is accepted in the following IDLE cycle, giving one idle cycle between accesses.
- Reset mid-operation:
  - Aborts immediately, with no completing beat.
  - `SRAM_WE_N` goes to 1 and `SRAM_DQ` is released asynchronously.
  - A partially written word is left as-is in SRAM.
- Request inputs must be stable from acceptance through DONE. Changes during ACCESS are ignored because all request fields are latched.

## Test plan
- Write then read, defaults: write 0xDEADBEEF at addr 0x8.
  - SRAM[4]=0xBEEF and SRAM[5]=0xDEAD.
  - `ready` low 5 cycles, then high 1 cycle.
  - A read at 0x8 returns `rdata`=0xDEADBEEF in DONE.
- WAIT_CYCLES=0, ADDR_OFFSET=0x400: write 0x12345678 at 0x404.
  - SRAM[2]=0x5678 and SRAM[3]=0x1234.
  - `ready` low exactly 3 cycles.
- Simultaneous `req_wr_en`=`req_rd_en`=1, wdata 0xA5A5A5A5 at 0x0:
  - The write occurs.
  - `rdata` is unchanged from its previous value (0 after reset).
- Address wrap, SRAM_ADDR_W=4: write at byte address 0x24 (word 9).
  - `SRAM_ADDR` beats are 2 and 3, i.e. 18 and 19 mod 16.
- Reset mid-write: assert rst low during beat 1 of a write.
  - Same cycle: `SRAM_WE_N`=1, `SRAM_DQ`=Z, `ready`=1.
  - After release, a new read completes normally.
- Back-to-back reads at 0x8 and 0xC, defaults:
  - Second access accepted one cycle after the first DONE.
  - Both `rdata` values correct.
  - `SRAM_DQ` is never driven by the controller during either read.

Source files
------------

// File: rtl/sram_ctrl.sv
// Core-to-async-SRAM bridge: one access = BEATS beats of WAIT_CYCLES+1 cycles each, low half-word first.
// Latency 1 + BEATS*(WAIT_CYCLES+1) cycles with ready low; ready pulses high for the single DONE cycle.
module sram_ctrl #(
   parameter int          DATA_W      = 32,
   parameter int          SRAM_DQ_W   = 16,
   parameter int          SRAM_ADDR_W = 18,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] ADDR_OFFSET = 32'h0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_wr_en,
   input  logic                   req_rd_en,
   input  logic [31:0]            req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic [DATA_W-1:0]      rdata,
   output logic                   ready,
   inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N
);

   localparam int BEATS   = DATA_W / SRAM_DQ_W;
   localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BEAT_SH = $clog2(BEATS);
   localparam int WORD_SH = $clog2(DATA_W / 8);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state;
   state_t              next_state;
   logic                op_wr;
   logic [31:0]         addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BEAT_W-1:0]   beat;
   logic [BEAT_W-1:0]   next_beat;
   logic [3:0]          wait_cnt;
   logic                req;
   logic                beat_end;
   logic                last_beat;
   logic                drive;

   function automatic logic [SRAM_ADDR_W-1:0] map_addr(input logic [31:0] a,
                                                       input logic [BEAT_W-1:0] b);
      return SRAM_ADDR_W'((((a - ADDR_OFFSET) >> WORD_SH) << BEAT_SH) + 32'(b));
   endfunction

   assign req       = req_wr_en | req_rd_en;
   assign beat_end  = (state == ACCESS) && (wait_cnt == 4'(WAIT_CYCLES));
   assign last_beat = (beat == BEAT_W'(BEATS - 1));
   assign next_beat = beat + 1'b1;

   // Pins follow the state register, so an async reset releases the bus at once.
   assign drive     = (state == ACCESS) && op_wr;
   assign SRAM_WE_N = ~drive;
   assign SRAM_DQ   = drive ? wdata_q[int'(beat)*SRAM_DQ_W +: SRAM_DQ_W] : 'z;
   assign ready     = ((state == IDLE) && !req) || (state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req) next_state = ACCESS;
         ACCESS:  if (beat_end && last_beat) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_wr     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         beat      <= '0;
         wait_cnt  <= '0;
         rdata     <= '0;
         SRAM_ADDR <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat     <= '0;
               wait_cnt <= '0;
               if (req) begin
                  op_wr     <= req_wr_en;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  SRAM_ADDR <= map_addr(req_addr, '0);
               end
            end
            ACCESS: begin
               if (beat_end) begin
                  if (!op_wr) rdata[int'(beat)*SRAM_DQ_W +: SRAM_DQ_W] <= SRAM_DQ;
                  wait_cnt <= '0;
                  if (!last_beat) begin
                     beat      <= next_beat;
                     SRAM_ADDR <= map_addr(addr_q, next_beat);
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three configurations (defaults, zero-wait with offset, 4-bit SRAM address),
// each attached to a simple SRAM model that drives the bus whenever WE_N is high.
module tb_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  wr = '0;
   logic [2:0]  rd = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;

   wire  [31:0] rdata0, rdata1, rdata2;
   wire  [2:0]  rdy;
   wire  [2:0]  we_n;
   wire  [15:0] dq0, dq1, dq2;
   wire  [17:0] sa0, sa1;
   wire  [3:0]  sa2;

   logic [15:0] mem0 [64] = '{default: 16'h0};
   logic [15:0] mem1 [64] = '{default: 16'h0};
   logic [15:0] mem2 [16] = '{default: 16'h0};

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sram_ctrl u0 (
      .clk(clk), .rst(rst), .req_wr_en(wr[0]), .req_rd_en(rd[0]), .req_addr(addr),
      .req_wdata(wdata), .rdata(rdata0), .ready(rdy[0]), .SRAM_DQ(dq0),
      .SRAM_ADDR(sa0), .SRAM_WE_N(we_n[0]));

   sram_ctrl #(.WAIT_CYCLES(0), .ADDR_OFFSET(32'h400)) u1 (
      .clk(clk), .rst(rst), .req_wr_en(wr[1]), .req_rd_en(rd[1]), .req_addr(addr),
      .req_wdata(wdata), .rdata(rdata1), .ready(rdy[1]), .SRAM_DQ(dq1),
      .SRAM_ADDR(sa1), .SRAM_WE_N(we_n[1]));

   sram_ctrl #(.SRAM_ADDR_W(4)) u2 (
      .clk(clk), .rst(rst), .req_wr_en(wr[2]), .req_rd_en(rd[2]), .req_addr(addr),
      .req_wdata(wdata), .rdata(rdata2), .ready(rdy[2]), .SRAM_DQ(dq2),
      .SRAM_ADDR(sa2), .SRAM_WE_N(we_n[2]));

   assign dq0 = we_n[0] ? mem0[sa0[5:0]] : 'z;
   assign dq1 = we_n[1] ? mem1[sa1[5:0]] : 'z;
   assign dq2 = we_n[2] ? mem2[sa2]      : 'z;

   always @(posedge clk) begin
      if (!we_n[0]) mem0[sa0[5:0]] <= dq0;
      if (!we_n[1]) mem1[sa1[5:0]] <= dq1;
      if (!we_n[2]) mem2[sa2]      <= dq2;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Any controller drive while WE_N is high would corrupt the model's read data on the bus.
   always @(negedge clk) begin
      #2;
      if (we_n[0]) check("dq_released", 32'(dq0), 32'(mem0[sa0[5:0]]));
   end

   task automatic access(input int sel, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d,
                         output int low, output logic [31:0] rv);
      @(negedge clk);
      addr = a;
      wdata = d;
      wr = '0;
      rd = '0;
      wr[sel] = w;
      rd[sel] = r;
      low = 0;
      #1;
      while (!rdy[sel] && low < 40) begin
         low++;
         @(negedge clk);
         #1;
      end
      if (low >= 40) begin
         checks++;
         errors++;
         $display("FAIL timeout: ready still low after %0d cycles, required high", low);
      end
      rv = (sel == 0) ? rdata0 : (sel == 1) ? rdata1 : rdata2;
   endtask

   task automatic release_req(input int sel);
      @(negedge clk);
      #1;
      check("done_one_cycle", 32'(rdy[sel]), 32'd0);
      wr = '0;
      rd = '0;
      #1;
      check("ready_idle", 32'(rdy[sel]), 32'd1);
   endtask

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      int          lo;
      logic [15:0] exp_lo;
      logic [15:0] exp_hi;
   } vec_t;

   vec_t vt [6];

   initial begin
      int          low;
      logic [31:0] rv;

      vt[0] = '{1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0,        0, 16'hA5A5, 16'hA5A5};
      vt[1] = '{1'b1, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0,        4, 16'hBEEF, 16'hDEAD};
      vt[2] = '{1'b0, 1'b1, 32'h8, 32'h0,        32'hDEADBEEF, 0, 16'h0,    16'h0};
      vt[3] = '{1'b1, 1'b0, 32'hC, 32'hCAFEF00D, 32'hDEADBEEF, 6, 16'hF00D, 16'hCAFE};
      vt[4] = '{1'b0, 1'b1, 32'hC, 32'h0,        32'hCAFEF00D, 0, 16'h0,    16'h0};
      vt[5] = '{1'b0, 1'b1, 32'h0, 32'h0,        32'hA5A5A5A5, 0, 16'h0,    16'h0};

      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", 32'(rdy), 32'h7);
      check("rst_we_n", 32'(we_n), 32'h7);
      check("rst_addr", 32'(sa0), 32'h0);
      check("rst_rdata", rdata0, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         access(0, vt[i].w, vt[i].r, vt[i].a, vt[i].d, low, rv);
         check($sformatf("vec%0d_latency", i), 32'(low), 32'd5);
         check($sformatf("vec%0d_rdata", i), rv, vt[i].exp_rd);
         if (vt[i].w) begin
            check($sformatf("vec%0d_mem_lo", i), 32'(mem0[vt[i].lo]), 32'(vt[i].exp_lo));
            check($sformatf("vec%0d_mem_hi", i), 32'(mem0[vt[i].lo + 1]), 32'(vt[i].exp_hi));
         end
         release_req(0);
      end

      // Zero wait states with address offset.
      access(1, 1'b1, 1'b0, 32'h404, 32'h12345678, low, rv);
      check("w0_wr_latency", 32'(low), 32'd3);
      check("w0_mem_lo", 32'(mem1[2]), 32'h5678);
      check("w0_mem_hi", 32'(mem1[3]), 32'h1234);
      release_req(1);
      access(1, 1'b0, 1'b1, 32'h404, 32'h0, low, rv);
      check("w0_rd_latency", 32'(low), 32'd3);
      check("w0_rdata", rv, 32'h12345678);
      release_req(1);

      // 4-bit SRAM address: word 9 maps to beats 18,19 which wrap to 2,3.
      @(negedge clk);
      addr = 32'h24;
      wdata = 32'h0BADCAFE;
      wr = 3'b100;
      @(negedge clk);
      #1;
      check("wrap_beat0_addr", 32'(sa2), 32'd2);
      check("wrap_beat0_we", 32'(we_n[2]), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      check("wrap_beat1_addr", 32'(sa2), 32'd3);
      low = 0;
      while (!rdy[2] && low < 40) begin
         low++;
         @(negedge clk);
         #1;
      end
      check("wrap_done", 32'(rdy[2]), 32'd1);
      check("wrap_mem_lo", 32'(mem2[2]), 32'hCAFE);
      check("wrap_mem_hi", 32'(mem2[3]), 32'h0BAD);
      release_req(2);

      // Reset asserted in the first cycle of beat 1 of a write.
      @(negedge clk);
      addr = 32'h10;
      wdata = 32'hFFFFFFFF;
      wr = 3'b001;
      repeat (3) @(negedge clk);
      #1;
      check("mid_wr_beat1_addr", 32'(sa0), 32'd9);
      check("mid_wr_we_low", 32'(we_n[0]), 32'd0);
      rst = 1'b0;
      wr = '0;
      #1;
      check("abort_we_n", 32'(we_n[0]), 32'd1);
      check("abort_ready", 32'(rdy[0]), 32'd1);
      check("abort_addr", 32'(sa0), 32'd0);
      check("abort_dq", 32'(dq0), 32'(mem0[0]));
      @(negedge clk);
      check("abort_mem_lo", 32'(mem0[8]), 32'hFFFF);
      check("abort_mem_hi", 32'(mem0[9]), 32'h0000);
      rst = 1'b1;
      access(0, 1'b0, 1'b1, 32'h10, 32'h0, low, rv);
      check("post_rst_latency", 32'(low), 32'd5);
      check("post_rst_rdata", rv, 32'h0000FFFF);
      release_req(0);

      // Back-to-back reads: the second is accepted in the IDLE cycle right after DONE.
      access(0, 1'b0, 1'b1, 32'h8, 32'h0, low, rv);
      check("b2b_first_latency", 32'(low), 32'd5);
      check("b2b_first_rdata", rv, 32'hDEADBEEF);
      access(0, 1'b0, 1'b1, 32'hC, 32'h0, low, rv);
      check("b2b_second_latency", 32'(low), 32'd5);
      check("b2b_second_rdata", rv, 32'hCAFEF00D);
      release_req(0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

endmodule
